// File: rtl/cs_add_sequencer.sv
// rtl/cs_add_sequencer.sv - multi-precision adder sequencing 16-bit slices through one carry-skip adder
// Wide add done LS slice first over NCHUNK cycles, with a registered carry between slices.

module carry_skip_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p;
  logic [15:0] g;
  logic [4:0]  blk_c;
  logic [4:0]  rc;

  assign p = a ^ b;
  assign g = a & b;

  // Four 4-bit ripple blocks; a block whose bits all propagate passes its carry-in straight on.
  always_comb begin
    blk_c    = '0;
    rc       = '0;
    sum      = '0;
    blk_c[0] = cin;
    for (int blk = 0; blk < 4; blk++) begin
      rc[0] = blk_c[blk];
      for (int i = 0; i < 4; i++) begin
        sum[4*blk+i] = p[4*blk+i] ^ rc[i];
        rc[i+1]      = g[4*blk+i] | (p[4*blk+i] & rc[i]);
      end
      blk_c[blk+1] = (&p[4*blk +: 4]) ? blk_c[blk] : rc[4];
    end
    cout = blk_c[4];
  end
endmodule

module cs_add_sequencer #(
  parameter int NCHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NCHUNK-1:0] in_a,
  input  logic [16*NCHUNK-1:0] in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*NCHUNK-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);
  localparam int W  = 16 * NCHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry;
  logic          cout_reg;
  logic          ovf_reg;
  logic [15:0]   slice_sum;
  logic          slice_cout;

  carry_skip_16bit u_adder (
    .a    (a_reg[16*idx +: 16]),
    .b    (b_reg[16*idx +: 16]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_reg[16*idx +: 16] <= slice_sum;
          carry                 <= slice_cout;
          if (idx == IW'(NCHUNK - 1)) begin
            cout_reg <= slice_cout;
            // slice_sum[15] is result bit W-1, so this recovers the carry into the MSB
            ovf_reg  <= a_reg[W-1] ^ b_reg[W-1] ^ slice_sum[15] ^ slice_cout;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;
endmodule

// File: tb/tb_cs_add_sequencer.sv
// tb/tb_cs_add_sequencer.sv - scoreboarded random and directed bench for cs_add_sequencer
// Driver pushes reference results on accept; a monitor pops them when out_valid rises.

module tb_cs_add_sequencer;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  cs_add_sequencer #(.NCHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    exp_t        m;
    logic [W:0]  full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    m.sum  = full[W-1:0];
    m.cout = full[W];
    m.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return m;
  endfunction

  // Monitor: one scoreboard pop per new result
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {63'd0, out_valid}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum", out_sum, e.sum);
          chk("cout", {63'd0, out_cout}, {63'd0, e.cout});
          chk("ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_wait", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    exp_q.push_back(model(a, b, cin));
    #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(input bit rand_ready);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) break;
      n++;
      if (n > 200) begin
        chk("result_wait", {63'd0, out_valid}, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_wait", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] hold_sum;
    logic         hold_cout;
    logic         hold_ovf;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] qa;
    logic [W-1:0] qb;

    // Reset idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_out_sum", out_sum, 64'd0);
    end

    // Basic add with latency
    out_ready = 1'b1;
    issue(64'd5, 64'd5, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_valid_e%0d", k), {63'd0, out_valid}, {63'd0, (k == 4)});
      chk($sformatf("lat_busy_e%0d", k), {63'd0, busy}, 64'd1);
    end
    chk("basic_sum_direct", out_sum, 64'h000B);
    @(posedge clk);
    #1;
    chk("consume_in_ready", {63'd0, in_ready}, 64'd1);
    chk("consume_out_valid", {63'd0, out_valid}, 64'd0);

    // Full ripple and signed overflow
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    wait_result(1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_result(1'b0);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_result(1'b0);
    issue(64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0);
    wait_result(1'b0);

    // Backpressure with a queued request
    out_ready = 1'b0;
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    wait_valid();
    hold_sum = out_sum; hold_cout = out_cout; hold_ovf = out_ovf;
    qa = {$urandom, $urandom};
    qb = {$urandom, $urandom};
    in_a = qa; in_b = qb; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_sum_stable", out_sum, hold_sum);
      chk("bp_flags_stable", {62'd0, out_cout, out_ovf}, {62'd0, hold_cout, hold_ovf});
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", {63'd0, in_ready}, 64'd1);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    exp_q.push_back(model(qa, qb, 1'b0));
    #1;
    chk("bp_queued_accept", {63'd0, busy}, 64'd1);
    in_valid = 1'b0;
    wait_result(1'b0);

    // Reset mid-op
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("postrst_valid", {63'd0, out_valid}, 64'd0);
      chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    end
    issue(64'd3, 64'd4, 1'b0);
    wait_result(1'b0);

    // Randomized operands with random consumer backpressure
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 4))
        0: begin ra = '1; rb = {$urandom, $urandom} & 64'h1; end
        1: begin ra = {$urandom, $urandom}; rb = ~ra; end
        2: begin ra = {1'b0, {63{1'b1}}}; rb = {$urandom, $urandom} & 64'hF; end
        default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)));
      wait_result(1'b1);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
